alu_issue_arb: RTL and testbench
================================

# alu_issue_arb

Two-requester arbiter and issue sequencer in front of the 8-bit registered ALU (opcodes ADD/SUB/NOT-B/AND/OR/XOR, two-edge internal latency). It accepts operations from two independent requesters over valid/ready, grants one per cycle by round-robin, and drives the ALU operand/instruction inputs from registers. It tracks every in-flight operation with a tag pipeline matched to the ALU latency and returns each result to its owner as a one-cycle response pulse.

## Interface
- DATA_W, 8, operand/result width; must match the ALU.
- ALU_LAT, 2, clock edges from the ALU capturing its inputs to a valid `alu_out`.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req0_valid / req1_valid  in  1  requester has an operation.
- req0_ready / req1_ready  out  1  grant, combinational; transfer on valid&ready.
- req0_ins / req1_ins  in  4  ALU opcode.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- alu_instruction  out  4  registered opcode to the ALU.
- alu_inputA, alu_inputB  out  DATA_W  registered operands to the ALU.
- alu_out  in  DATA_W  ALU result.
- rsp_valid  out  1  one-cycle result pulse; no backpressure.
- rsp_id  out  1  owner of the result (0/1).
- rsp_data  out  DATA_W  result value.
- busy  out  1  at least one operation in flight (not yet presented on rsp_*).

## Operation
- Arbitration: at most one grant per cycle. `prio` register selects the preferred requester; reset value 0.
  - Only one valid: that requester is granted regardless of `prio`.
  - Both valid: the `prio` requester is granted.
  - On every transfer, `prio` becomes the non-granted index, so continuous contention alternates 0,1,0,1.
  - No transfer: `prio` holds.
- `reqX_ready` depends only on both valids and `prio`. Requesters must not make valid depend on ready.
- Issue: on a transfer, the granted ins/a/b are registered into `alu_instruction`/`alu_inputA`/`alu_inputB`. With no transfer these hold their previous values. The ALU keeps computing on them, but the result is discarded because no tag is valid.
- Tag pipeline: ALU_LAT+1 stages, each holding {valid, id}.
  - Stage 0 loads {transfer, granted id}.
  - Each stage shifts every cycle; there are no stalls.
  - When the last stage is valid, the next edge loads `rsp_data`←`alu_out` and `rsp_id`←stage id, and asserts `rsp_valid`.
  - `rsp_valid` is otherwise 0.
- Results are returned in issue order, and are whatever the ALU produces: mod-2^DATA_W wrap for ADD/SUB; opcodes 5–15 behave as XOR. No opcode checking.
- `busy` = OR of all tag-stage valid bits.

## Timing
- Reset (asynchronous assert): all outputs 0 (`rsp_valid`, `rsp_id`, `rsp_data`, `alu_*`, `busy`); tags cleared; `prio`=0. `req*_ready` reflects the arbitration rule immediately, because it is combinational.
- Reset mid-operation: in-flight operations are dropped, and no `rsp_valid` ever appears for them.
- Latency for a transfer at edge E0:
  - E0: `alu_*` registered.
  - E1: ALU captures.
  - E2: `alu_out` valid.
  - E3: `rsp_*` registered; `rsp_valid` high for the cycle after E3.
  - Total: ALU_LAT+1 = 3 edges.
- Throughput is one operation per cycle. Back-to-back transfers give back-to-back `rsp_valid` pulses.
- Simultaneous events: a transfer and a response in the same cycle are independent. Both requesters valid is resolved purely by `prio`.

## Structure
- Shared package `alu_pkg`:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_NOTB=2, OP_AND=3, OP_OR=4, OP_XOR=5;
  - DATA_W default and ALU_LAT default;
  - the in-flight tag struct {valid, id}.
- Sub-module `rr_arb2`: combinational 2-way grant from valid[1:0] and `prio`, plus the `prio` update register.
- The top holds the issue registers, the tag shift register and the response registers. The ALU is instantiated alongside at the level above, with its active-low reset driven by the inverted `reset`.

## Test plan
- Req0 ADD a=8'h0F b=8'h01 at E0 -> `rsp_valid` after E3 with `rsp_id`=0, `rsp_data`=8'h10; `busy` high for 3 cycles.
- Req1 SUB a=8'h00 b=8'h01 -> `rsp_id`=1, `rsp_data`=8'hFF. Req1 NOT-B b=8'hA5 -> 8'h5A.
- Both valid for 4 cycles, starting from `prio`=0 -> grants 0,1,0,1; four consecutive `rsp_valid` pulses with ids 0,1,0,1 and matching results.
- Req0 alone valid for 3 cycles while `prio`=1 -> granted every cycle; results in issue order.
- Issue 2 ops, assert reset one cycle later -> all outputs 0 immediately; no `rsp_valid` after release; next op after release returns correctly with `prio`=0.
- Opcode 4'hF a=8'hF0 b=8'h3C -> `rsp_data`=8'hCC (XOR).

Source files
------------

// File: rtl/alu_issue_arb_pkg.sv
// Shared definitions for the ALU issue arbiter: opcodes, default widths and the
// in-flight tag record.
package alu_pkg;
  localparam int DATA_W  = 8;
  localparam int ALU_LAT = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOTB = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;
endpackage

// File: rtl/alu_issue_arb_if.sv
// Requester, ALU and response signals of the issue arbiter.
// The slave side is the arbiter; the master side is its environment.
interface alu_issue_arb_if #(parameter int DATA_W = alu_pkg::DATA_W);
  logic              req0_valid, req0_ready;
  logic [3:0]        req0_ins;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [3:0]        req1_ins;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [3:0]        alu_instruction;
  logic [DATA_W-1:0] alu_inputA, alu_inputB;
  logic [DATA_W-1:0] alu_out;
  logic              rsp_valid, rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport slave (
    input  req0_valid, req0_ins, req0_a, req0_b,
    input  req1_valid, req1_ins, req1_a, req1_b,
    input  alu_out,
    output req0_ready, req1_ready,
    output alu_instruction, alu_inputA, alu_inputB,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_ins, req0_a, req0_b,
    output req1_valid, req1_ins, req1_a, req1_b,
    output alu_out,
    input  req0_ready, req1_ready,
    input  alu_instruction, alu_inputA, alu_inputB,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/alu_issue_arb_rr_arb2.sv
// Two-way round-robin grant. The preferred index only matters under contention;
// after every transfer the loser becomes preferred.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       xfer,
  output logic       gnt_id
);
  logic prio;

  always_comb begin
    grant = valid;
    if (valid == 2'b11)
      grant = prio ? 2'b10 : 2'b01;
  end

  assign xfer   = |valid;
  assign gnt_id = grant[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prio <= 1'b0;
    else if (xfer)
      prio <= ~gnt_id;
  end
endmodule

// File: rtl/alu_issue_arb.sv
// Arbitrates two requesters onto the registered ALU and returns each result
// to its owner, tracked by a tag pipeline matched to the ALU latency.
module alu_issue_arb
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int ALU_LAT = alu_pkg::ALU_LAT
) (
  input logic            clk,
  input logic            reset,
  alu_issue_arb_if.slave bus
);
  logic [1:0]        grant;
  logic              xfer, gnt_id;
  logic [3:0]        sel_ins;
  logic [DATA_W-1:0] sel_a, sel_b;
  tag_t              tags [ALU_LAT+1];

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .grant  (grant),
    .xfer   (xfer),
    .gnt_id (gnt_id)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign sel_ins = gnt_id ? bus.req1_ins : bus.req0_ins;
  assign sel_a   = gnt_id ? bus.req1_a   : bus.req0_a;
  assign sel_b   = gnt_id ? bus.req1_b   : bus.req0_b;

  // Operands hold when idle; the ALU's result on them is ignored since no tag rides along.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.alu_instruction <= '0;
      bus.alu_inputA      <= '0;
      bus.alu_inputB      <= '0;
    end else if (xfer) begin
      bus.alu_instruction <= sel_ins;
      bus.alu_inputA      <= sel_a;
      bus.alu_inputB      <= sel_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= ALU_LAT; i++)
        tags[i] <= '0;
    end else begin
      tags[0].valid <= xfer;
      tags[0].id    <= gnt_id;
      for (int i = 1; i <= ALU_LAT; i++)
        tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= tags[ALU_LAT].valid;
      if (tags[ALU_LAT].valid) begin
        bus.rsp_id   <= tags[ALU_LAT].id;
        bus.rsp_data <= bus.alu_out;
      end
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    for (int i = 0; i <= ALU_LAT; i++)
      bus.busy = bus.busy | tags[i].valid;
  end
endmodule

// File: tb/tb_alu_issue_arb.sv
// Bench for alu_issue_arb: a two-edge ALU model beside the DUT, directed cases
// and randomized traffic checked against a queue of expected responses.
module tb_alu_issue_arb;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_arb_if #(.DATA_W(8)) bus ();

  alu_issue_arb #(.DATA_W(8), .ALU_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return ~b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // External ALU: captures on one edge, result valid after the next.
  logic       alu_rst_b;
  logic [3:0] cap_ins;
  logic [7:0] cap_a, cap_b;
  assign alu_rst_b = ~reset;
  always_ff @(posedge clk or negedge alu_rst_b) begin
    if (!alu_rst_b) begin
      cap_ins     <= '0;
      cap_a       <= '0;
      cap_b       <= '0;
      bus.alu_out <= '0;
    end else begin
      cap_ins     <= bus.alu_instruction;
      cap_a       <= bus.alu_inputA;
      cap_b       <= bus.alu_inputB;
      bus.alu_out <= alu_f(cap_ins, cap_a, cap_b);
    end
  end

  typedef struct {
    int         due;
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  logic        m_prio = 1'b0;
  logic [19:0] m_iss = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check grants, advance the model, check registered outputs.
  task automatic step(input logic v0, input logic [3:0] i0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic v1, input logic [3:0] i1, input logic [7:0] a1, input logic [7:0] b1);
    logic g, xf;
    bus.req0_valid = v0; bus.req0_ins = i0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_ins = i1; bus.req1_a = a1; bus.req1_b = b1;
    xf = v0 | v1;
    g  = (v0 && v1) ? m_prio : v1;
    #1;
    check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, xf && !g});
    check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, xf && g});
    @(posedge clk);
    cyc++;
    if (xf) begin
      m_prio = ~g;
      m_iss  = g ? {i1, a1, b1} : {i0, a0, b0};
      q.push_back('{cyc + 3, g, g ? alu_f(i1, a1, b1) : alu_f(i0, a0, b0)});
    end
    #1;
    check("alu_issue", {12'd0, bus.alu_instruction, bus.alu_inputA, bus.alu_inputB}, {12'd0, m_iss});
    if (q.size() > 0 && q[0].due == cyc) begin
      check("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("rsp_id",    {31'd0, bus.rsp_id},    {31'd0, q[0].id});
      check("rsp_data",  {24'd0, bus.rsp_data},  {24'd0, q[0].data});
      void'(q.pop_front());
    end else begin
      check("rsp_valid_idle", {31'd0, bus.rsp_valid}, 32'd0);
    end
    check("busy", {31'd0, bus.busy}, {31'd0, q.size() > 0});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
    check("rst_rsp_data",  {24'd0, bus.rsp_data},  32'd0);
    check("rst_alu",       {12'd0, bus.alu_instruction, bus.alu_inputA, bus.alu_inputB}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    q.delete();
    m_prio = 1'b0;
    m_iss  = '0;
    #1;
    check_reset_outputs();
    check("rst_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_ins = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_ins = 0; bus.req1_a = 0; bus.req1_b = 0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    step(1, OP_ADD, 8'h0F, 8'h01, 0, 0, 0, 0);
    idle(4);
    step(0, 0, 0, 0, 1, OP_SUB, 8'h00, 8'h01);
    step(0, 0, 0, 0, 1, OP_NOTB, 8'h00, 8'hA5);
    idle(4);

    step(1, OP_ADD, 8'h11, 8'h22, 1, OP_SUB, 8'h50, 8'h60);
    step(1, OP_AND, 8'hF0, 8'h3C, 1, OP_OR,  8'h0F, 8'h30);
    step(1, OP_XOR, 8'hAA, 8'hFF, 1, OP_NOTB, 8'h00, 8'h0F);
    step(1, OP_ADD, 8'hFF, 8'h02, 1, OP_SUB, 8'h03, 8'h04);
    idle(4);

    step(1, OP_ADD, 8'h01, 8'h01, 0, 0, 0, 0);
    step(1, OP_ADD, 8'h10, 8'h20, 0, 0, 0, 0);
    step(1, OP_SUB, 8'h10, 8'h20, 0, 0, 0, 0);
    step(1, OP_OR,  8'h81, 8'h18, 0, 0, 0, 0);
    idle(4);

    step(1, OP_ADD, 8'h05, 8'h06, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, OP_SUB, 8'h09, 8'h01);
    do_reset();
    idle(5);
    step(1, OP_ADD, 8'h21, 8'h12, 1, OP_SUB, 8'h44, 8'h11);
    idle(4);

    step(1, 4'hF, 8'hF0, 8'h3C, 0, 0, 0, 0);
    idle(4);

    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
           $urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    idle(5);
    check("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
